// File: rtl/core_bridge_host.sv
// Host emulator for core_bridge_cmd: writes parameter words and the command semaphore,
// polls status until OK (or timeout), then reads back the four response words.
//
// state      | meaning
// IDLE       | cmd_ready high, waiting for a command
// WR_PARAM   | one parameter word written per cycle at +0x20+4i
// WR_CMD     | semaphore {0x434D,code} written at +0x00, timeout armed
// GAP        | idle spacing between status polls
// POLL_RD    | status read strobe at +0x00
// POLL_WAIT  | waiting RD_LATENCY cycles, then classify status word
// RSP_RD     | response read strobe at +0x40..+0x4C
// RSP_WAIT   | waiting RD_LATENCY cycles, then capture response word
// DONE       | response held until rsp_ready
module core_bridge_host #(
    parameter logic [31:0] BASE_ADDR  = 32'hF800_0000,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned POLL_GAP   = 8,
    parameter logic [31:0] TIMEOUT    = 32'd1_000_000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [15:0]  cmd_code,
    input  logic [2:0]   cmd_nparam,
    input  logic [127:0] cmd_param,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [15:0]  rsp_code,
    output logic [127:0] rsp_data,
    output logic         rsp_timeout,
    output logic         bridge_endian_little,
    output logic [31:0]  bridge_addr,
    output logic         bridge_rd,
    input  logic [31:0]  bridge_rd_data,
    output logic         bridge_wr,
    output logic [31:0]  bridge_wr_data
);
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_WR_PARAM  = 4'd1;
    localparam logic [3:0] S_WR_CMD    = 4'd2;
    localparam logic [3:0] S_GAP       = 4'd3;
    localparam logic [3:0] S_POLL_RD   = 4'd4;
    localparam logic [3:0] S_POLL_WAIT = 4'd5;
    localparam logic [3:0] S_RSP_RD    = 4'd6;
    localparam logic [3:0] S_RSP_WAIT  = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;

    localparam logic [15:0] SEM_TAG   = 16'h434D;
    localparam logic [15:0] OK_TAG    = 16'h4F4B;
    localparam logic [31:0] OFS_PARAM = 32'h20;
    localparam logic [31:0] OFS_RSP   = 32'h40;
    localparam logic [1:0]  LAT_LOAD  = 2'(RD_LATENCY - 1);
    localparam logic [31:0] GAP_LOAD  = (POLL_GAP == 0) ? 32'd0 : 32'(POLL_GAP - 1);

    logic [3:0]   state;
    logic [15:0]  code_q;
    logic [127:0] param_q;
    logic [2:0]   nparam_q;
    logic [1:0]   widx;
    logic [1:0]   ridx;
    logic [1:0]   lat_cnt;
    logic [31:0]  gap_cnt;
    logic [31:0]  tmo_cnt;

    logic [2:0]   nparam_clamp;
    logic [1:0]   widx_nx;
    logic [1:0]   ridx_nx;
    logic         tmo_hit;
    logic         in_poll;

    assign bridge_endian_little = 1'b0;
    assign nparam_clamp = (cmd_nparam > 3'd4) ? 3'd4 : cmd_nparam;
    assign widx_nx      = widx + 2'd1;
    assign ridx_nx      = ridx + 2'd1;
    assign tmo_hit      = (tmo_cnt == 32'd0);
    assign in_poll      = (state == S_GAP) || (state == S_POLL_RD) || (state == S_POLL_WAIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_timeout    <= 1'b0;
            rsp_code       <= 16'd0;
            rsp_data       <= 128'd0;
            bridge_addr    <= BASE_ADDR;
            bridge_rd      <= 1'b0;
            bridge_wr      <= 1'b0;
            bridge_wr_data <= 32'd0;
            code_q         <= 16'd0;
            param_q        <= 128'd0;
            nparam_q       <= 3'd0;
            widx           <= 2'd0;
            ridx           <= 2'd0;
            lat_cnt        <= 2'd0;
            gap_cnt        <= 32'd0;
            tmo_cnt        <= 32'd0;
        end else begin
            if (in_poll && !tmo_hit) begin
                tmo_cnt <= tmo_cnt - 32'd1;
            end
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        code_q    <= cmd_code;
                        param_q   <= cmd_param;
                        nparam_q  <= nparam_clamp;
                        rsp_code  <= 16'd0;
                        rsp_data  <= 128'd0;
                        widx      <= 2'd0;
                        bridge_wr <= 1'b1;
                        if (nparam_clamp == 3'd0) begin
                            bridge_addr    <= BASE_ADDR;
                            bridge_wr_data <= {SEM_TAG, cmd_code};
                            state          <= S_WR_CMD;
                        end else begin
                            bridge_addr    <= BASE_ADDR + OFS_PARAM;
                            bridge_wr_data <= cmd_param[31:0];
                            state          <= S_WR_PARAM;
                        end
                    end
                end
                S_WR_PARAM: begin
                    if (({1'b0, widx} + 3'd1) == nparam_q) begin
                        bridge_addr    <= BASE_ADDR;
                        bridge_wr_data <= {SEM_TAG, code_q};
                        state          <= S_WR_CMD;
                    end else begin
                        widx           <= widx_nx;
                        bridge_addr    <= BASE_ADDR + OFS_PARAM + {28'd0, widx_nx, 2'b00};
                        bridge_wr_data <= param_q[{widx_nx, 5'd0} +: 32];
                    end
                end
                S_WR_CMD: begin
                    bridge_wr <= 1'b0;
                    tmo_cnt   <= TIMEOUT;
                    if (POLL_GAP == 0) begin
                        bridge_rd   <= 1'b1;
                        bridge_addr <= BASE_ADDR;
                        state       <= S_POLL_RD;
                    end else begin
                        gap_cnt <= GAP_LOAD;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (tmo_hit) begin
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= S_DONE;
                    end else if (gap_cnt == 32'd0) begin
                        bridge_rd   <= 1'b1;
                        bridge_addr <= BASE_ADDR;
                        state       <= S_POLL_RD;
                    end else begin
                        gap_cnt <= gap_cnt - 32'd1;
                    end
                end
                S_POLL_RD: begin
                    bridge_rd <= 1'b0;
                    lat_cnt   <= LAT_LOAD;
                    state     <= S_POLL_WAIT;
                end
                S_POLL_WAIT: begin
                    if (lat_cnt != 2'd0) begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end else if (tmo_hit) begin
                        // read already completed; its data is dropped on timeout
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= S_DONE;
                    end else if (bridge_rd_data[31:16] == OK_TAG) begin
                        rsp_code    <= bridge_rd_data[15:0];
                        ridx        <= 2'd0;
                        bridge_rd   <= 1'b1;
                        bridge_addr <= BASE_ADDR + OFS_RSP;
                        state       <= S_RSP_RD;
                    end else if (POLL_GAP == 0) begin
                        bridge_rd   <= 1'b1;
                        bridge_addr <= BASE_ADDR;
                        state       <= S_POLL_RD;
                    end else begin
                        gap_cnt <= GAP_LOAD;
                        state   <= S_GAP;
                    end
                end
                S_RSP_RD: begin
                    bridge_rd <= 1'b0;
                    lat_cnt   <= LAT_LOAD;
                    state     <= S_RSP_WAIT;
                end
                S_RSP_WAIT: begin
                    if (lat_cnt != 2'd0) begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end else begin
                        rsp_data[{ridx, 5'd0} +: 32] <= bridge_rd_data;
                        if (ridx == 2'd3) begin
                            rsp_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            ridx        <= ridx_nx;
                            bridge_rd   <= 1'b1;
                            bridge_addr <= BASE_ADDR + OFS_RSP + {28'd0, ridx_nx, 2'b00};
                            state       <= S_RSP_RD;
                        end
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_timeout <= 1'b0;
                        cmd_ready   <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_bridge_host.sv
// Bench for core_bridge_host: a behavioural bridge responder plus a transaction-level
// model of the expected write list, poll cadence, response reads and latency.
module tb_core_bridge_host;
    localparam logic [31:0] BASE     = 32'hF800_0000;
    localparam logic [31:0] BASE_RSP = 32'hF800_0040;
    localparam int          LAT      = 2;
    localparam int          GAP      = 3;
    localparam logic [31:0] TMO      = 32'd200;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [15:0]  cmd_code;
    logic [2:0]   cmd_nparam;
    logic [127:0] cmd_param;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [15:0]  rsp_code;
    logic [127:0] rsp_data;
    logic         rsp_timeout;
    logic         bridge_endian_little;
    logic [31:0]  bridge_addr;
    logic         bridge_rd;
    logic [31:0]  bridge_rd_data;
    logic         bridge_wr;
    logic [31:0]  bridge_wr_data;

    core_bridge_host #(
        .BASE_ADDR (BASE),
        .RD_LATENCY(LAT),
        .POLL_GAP  (GAP),
        .TIMEOUT   (TMO)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_code            (cmd_code),
        .cmd_nparam          (cmd_nparam),
        .cmd_param           (cmd_param),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_code            (rsp_code),
        .rsp_data            (rsp_data),
        .rsp_timeout         (rsp_timeout),
        .bridge_endian_little(bridge_endian_little),
        .bridge_addr         (bridge_addr),
        .bridge_rd           (bridge_rd),
        .bridge_rd_data      (bridge_rd_data),
        .bridge_wr           (bridge_wr),
        .bridge_wr_data      (bridge_wr_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // responder configuration
    logic [15:0] r_code;
    logic [15:0] r_rc;
    int          r_busy;
    int          r_polls;
    bit          r_never;
    logic [31:0] r_regs [4];

    // observation logs
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          wr_cyc_q  [$];
    int          poll_cyc_q[$];
    logic [31:0] rsp_rd_q  [$];
    int          strobe_total = 0;
    int          excl_err = 0;
    int          stab_err = 0;
    int          hold_cnt = 0;
    logic [31:0] hold_addr;
    logic [31:0] s0 = 32'hFFFF_FFFF;
    logic [31:0] s1 = 32'hFFFF_FFFF;

    // read data appears in the cycle LAT cycles after the strobe; junk elsewhere never looks OK
    always @(negedge clk) begin
        logic [31:0] v;
        bridge_rd_data = s1;
        s1 = s0;
        v = $urandom | 32'h8000_0000;
        if (bridge_rd) begin
            if (bridge_addr == BASE) begin
                poll_cyc_q.push_back(cyc);
                if (r_never || r_polls < r_busy)
                    v = {(r_polls % 2 == 1) ? 16'h4255 : 16'h434D, r_code};
                else
                    v = {16'h4F4B, r_rc};
                r_polls++;
            end else if (bridge_addr[31:4] == BASE_RSP[31:4]) begin
                rsp_rd_q.push_back(bridge_addr);
                v = r_regs[bridge_addr[3:2]];
            end
        end
        s0 = v;
        if (bridge_wr) begin
            wr_addr_q.push_back(bridge_addr);
            wr_data_q.push_back(bridge_wr_data);
            wr_cyc_q.push_back(cyc);
        end
        if (bridge_rd || bridge_wr) strobe_total++;
        if (bridge_rd && bridge_wr) excl_err++;
        if (bridge_rd) begin
            hold_addr = bridge_addr;
            hold_cnt  = LAT;
        end else if (hold_cnt > 0) begin
            if (bridge_addr != hold_addr) stab_err++;
            hold_cnt--;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        poll_cyc_q.delete();
        rsp_rd_q.delete();
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_cmd(input logic [15:0] code, input logic [2:0] np, input logic [127:0] prm,
                           input int busy, input logic [15:0] rc, input bit never,
                           input logic [127:0] regs);
        int n, t, v, bad, h;
        bit ok;
        logic [15:0]  code_hold;
        logic [127:0] data_hold;
        n = (np > 3'd4) ? 4 : int'(np);
        r_code = code; r_rc = rc; r_busy = busy; r_never = never; r_polls = 0;
        for (int i = 0; i < 4; i++) r_regs[i] = regs[32*i +: 32];
        clear_logs();
        ok = cmd_ready;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            ok = cmd_ready;
        end
        check("ready_wait", ok, 1'b1);
        cmd_valid = 1'b1; cmd_code = code; cmd_nparam = np; cmd_param = prm;
        rsp_ready = 1'b1;
        t = cyc;
        step();
        check("ready_drop", cmd_ready, 1'b0);
        cmd_code = ~code; cmd_nparam = 3'd0;
        repeat (3) step();
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        for (int i = 0; i < 1000 && !rsp_valid; i++) step();
        check("rsp_wait", rsp_valid, 1'b1);
        v = cyc;

        check("wr_cnt", wr_addr_q.size(), n + 1);
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check("param_addr", wr_addr_q[i], BASE + 32'h20 + 32'(4 * i));
            check("param_data", wr_data_q[i], prm[32*i +: 32]);
        end
        if (wr_addr_q.size() > n) begin
            check("sem_wr", {wr_addr_q[n], wr_data_q[n]}, {BASE, 16'h434D, code});
            check("sem_cycle", wr_cyc_q[n], t + n + 1);
        end

        if (!never) begin
            check("poll_cnt", poll_cyc_q.size(), busy + 1);
            if (poll_cyc_q.size() > 0) check("first_poll", poll_cyc_q[0], t + n + 2 + GAP);
            bad = 0;
            for (int i = 1; i < poll_cyc_q.size(); i++)
                if (poll_cyc_q[i] - poll_cyc_q[i-1] != GAP + 1 + LAT) bad++;
            check("poll_spacing", bad, 0);
            check("rsp_latency", v - t, n + 2 + (busy + 1) * (GAP + 1 + LAT) + 4 * (1 + LAT));
            check("rsp_rd_cnt", rsp_rd_q.size(), 4);
            for (int i = 0; i < 4 && i < rsp_rd_q.size(); i++)
                check("rsp_rd_addr", rsp_rd_q[i], BASE_RSP + 32'(4 * i));
            check("rsp_code", rsp_code, rc);
            check("rsp_data", rsp_data, regs);
            check("rsp_timeout", rsp_timeout, 1'b0);
        end else begin
            check("tmo_flag", rsp_timeout, 1'b1);
            check("tmo_code", rsp_code, 16'd0);
            check("tmo_data", rsp_data, 128'd0);
            check("tmo_no_rsp_rd", rsp_rd_q.size(), 0);
            if (wr_cyc_q.size() > n)
                check("tmo_window", ((v - wr_cyc_q[n]) >= int'(TMO)) &&
                      ((v - wr_cyc_q[n]) <= int'(TMO) + GAP + LAT + 4), 1'b1);
        end

        code_hold = rsp_code; data_hold = rsp_data;
        h = $urandom_range(1, 3);
        repeat (h) step();
        check("rsp_hold", {rsp_valid, rsp_code, rsp_data}, {1'b1, code_hold, data_hold});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rsp_release", {rsp_valid, rsp_timeout, cmd_ready}, 3'b001);
    endtask

    initial begin
        int k, base_strobes;
        bit ok;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_code = 16'd0; cmd_nparam = 3'd0;
        cmd_param = 128'd0; rsp_ready = 1'b0;
        r_code = 16'd0; r_rc = 16'd0; r_busy = 0; r_polls = 0; r_never = 1'b0;
        for (int i = 0; i < 4; i++) r_regs[i] = 32'd0;
        step(); step();
        check("rst_outputs", {cmd_ready, rsp_valid, rsp_timeout, bridge_rd, bridge_wr}, 5'd0);
        check("rst_addr", bridge_addr, BASE);
        check("rst_wdata", bridge_wr_data, 32'd0);
        check("rst_rsp", {rsp_code, rsp_data}, 144'd0);
        check("endian", bridge_endian_little, 1'b0);
        reset_n = 1'b1;
        step();
        check("ready_after_rst", cmd_ready, 1'b1);

        run_cmd(16'h0011, 3'd0, 128'd0, 0, 16'h0000, 1'b0, rand128());
        run_cmd(16'h0080, 3'd1, 128'h3, 3, 16'h0002, 1'b0, rand128());
        run_cmd(16'h00A0, 3'd0, 128'd0, 0, 16'h0000, 1'b0,
                {32'h0, 32'h2000, 32'h100, 32'h1});
        run_cmd(16'h1234, 3'd2, rand128(), 1, 16'hFFFF, 1'b0, rand128());
        run_cmd(16'h0055, 3'd4, rand128(), 0, 16'h0000, 1'b1, rand128());
        for (int i = 0; i < 10; i++)
            run_cmd(16'($urandom), 3'($urandom_range(0, 7)), rand128(),
                    $urandom_range(0, 4), 16'($urandom), 1'b0, rand128());

        // reset while a status read is in flight
        r_never = 1'b1; r_polls = 0;
        clear_logs();
        ok = cmd_ready;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            ok = cmd_ready;
        end
        cmd_valid = 1'b1; cmd_code = 16'h0077; cmd_nparam = 3'd0; cmd_param = 128'd0;
        step();
        cmd_code = 16'h0099;
        k = 0;
        while (k < 200 && !(bridge_rd && bridge_addr == BASE)) begin
            step();
            k++;
        end
        check("mid_poll_seen", bridge_rd && bridge_addr == BASE, 1'b1);
        check("busy_no_accept", wr_addr_q.size(), 1);
        step();
        reset_n = 1'b0;
        #1;
        check("mid_rst_outputs", {cmd_ready, rsp_valid, rsp_timeout, bridge_rd, bridge_wr}, 5'd0);
        check("mid_rst_addr", {bridge_addr, bridge_wr_data}, {BASE, 32'd0});
        check("mid_rst_rsp", {rsp_code, rsp_data}, 144'd0);
        base_strobes = strobe_total;
        repeat (3) step();
        check("rst_hold_ready", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
        reset_n = 1'b1;
        step();
        check("rst_exit_ready", cmd_ready, 1'b1);
        repeat (4) step();
        check("no_strobe_after_rst", strobe_total, base_strobes);
        r_never = 1'b0;
        run_cmd(16'h0011, 3'd3, rand128(), 2, 16'h0000, 1'b0, rand128());

        check("rd_wr_exclusive", excl_err, 0);
        check("rd_addr_stable", stab_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
